tdr_bank: RTL and testbench

TDR_BANK -- requirements
Module: tdr_bank

---
 rtl/tdr_pkg.sv | 44 ++++
 rtl/tdr_chan.sv | 71 +++++++
 rtl/tdr_bank.sv | 94 +++++++++
 tb/tb_tdr_bank.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/tdr_pkg.sv
// Shared constants, decode result type and address decode helper.
// Used by tdr_bank (decode) and tdr_chan (data widths).
package tdr_pkg;

  localparam int unsigned ADDR_W    = 12;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned LSB_OFS   = 0;
  localparam int unsigned MSB_OFS   = 4;
  localparam int unsigned CH_STRIDE = 8;

  typedef struct packed {
    logic       lo;
    logic       hi;
    logic       stat;
    logic [2:0] ch;
  } dec_t;

  // Classify a byte address as channel LSB/MSB, status or unmapped.
  // Addresses that fall inside a channel slot but not on one of its
  // two registers are unmapped.
  function automatic dec_t tdr_decode(
    input logic [ADDR_W-1:0] a,
    input logic [ADDR_W-1:0] base,
    input logic [ADDR_W-1:0] stat,
    input int unsigned       nch
  );
    dec_t              d;
    logic [ADDR_W-1:0] off;
    logic [2:0]        sub;
    d   = '0;
    off = a - base;
    sub = off[2:0];
    if (a == stat) begin
      d.stat = 1'b1;
    end else if ((a >= base) &&
                 (off < ADDR_W'(nch * CH_STRIDE))) begin
      d.ch = off[5:3];
      d.lo = (sub == 3'(LSB_OFS));
      d.hi = (sub == 3'(MSB_OFS));
    end
    return d;
  endfunction

endpackage

// File: rtl/tdr_chan.sv
// One timer channel: counter, LSB write shadow, MSB read snapshot
// and sticky overflow flag.
// Ports: clk_i/rst_i (sync high), inc_i count enable, wr_lo_i/wr_hi_i
// write strobes, rd_lo_i LSB read strobe, clr_i W1C, data inputs,
// cnt_lo_o live counter low word, snap_o MSB snapshot, ovf_o flag.
import tdr_pkg::*;

module tdr_chan #(
  parameter int unsigned CNT_W = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              inc_i,
  input  logic              wr_lo_i,
  input  logic              wr_hi_i,
  input  logic              rd_lo_i,
  input  logic              clr_i,
  input  logic [DATA_W-1:0] lo_data_i,
  input  logic [CNT_W-33:0] hi_data_i,
  output logic [DATA_W-1:0] cnt_lo_o,
  output logic [CNT_W-33:0] snap_o,
  output logic              ovf_o
);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shadow_q, shadow_d;
  logic [CNT_W-33:0] snap_q, snap_d;
  logic              ovf_q, ovf_d;

  always_comb begin
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    snap_d   = snap_q;
    // Clear first, so a same-cycle wrap re-sets the flag.
    ovf_d    = ovf_q & ~clr_i;
    if (wr_lo_i) begin
      shadow_d = lo_data_i;
    end
    // Freeze the upper half as the LSB is read, for a coherent pair.
    if (rd_lo_i) begin
      snap_d = cnt_q[CNT_W-1:32];
    end
    if (wr_hi_i) begin
      cnt_d = {hi_data_i, shadow_q};
    end else if (inc_i) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (&cnt_q) begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      shadow_q <= '0;
      snap_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      snap_q   <= snap_d;
      ovf_q    <= ovf_d;
    end
  end

  assign cnt_lo_o = cnt_q[31:0];
  assign snap_o   = snap_q;
  assign ovf_o    = ovf_q;

endmodule

// File: rtl/tdr_bank.sv
// Bank of CH_NUM free-running timers behind a 32-bit register port.
// Ports: sys_clk/sys_rst, wr_en/rd_en/addr/wr_data access, cnt_en,
// halt, rd_data/rd_valid (1-cycle read), ovf sticky flags.
import tdr_pkg::*;

module tdr_bank #(
  parameter int unsigned       CH_NUM    = 2,
  parameter int unsigned       CNT_W     = 64,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 12'h4,
  parameter logic [ADDR_W-1:0] STAT_ADDR = 12'h40
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [CH_NUM-1:0] cnt_en,
  input  logic              halt,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [CH_NUM-1:0] ovf
);

  dec_t              dec;
  logic [DATA_W-1:0] lo_a [CH_NUM];
  logic [CNT_W-33:0] hi_a [CH_NUM];
  logic [DATA_W-1:0] rdat;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;

  assign dec = tdr_decode(addr, BASE_ADDR, STAT_ADDR, CH_NUM);

  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    logic sel;
    assign sel = (dec.ch == 3'(i));

    tdr_chan #(
      .CNT_W(CNT_W)
    ) u_chan (
      .clk_i    (sys_clk),
      .rst_i    (sys_rst),
      .inc_i    (cnt_en[i] & ~halt),
      .wr_lo_i  (wr_en & sel & dec.lo),
      .wr_hi_i  (wr_en & sel & dec.hi),
      .rd_lo_i  (rd_en & sel & dec.lo),
      .clr_i    (wr_en & dec.stat & wr_data[i]),
      .lo_data_i(wr_data),
      .hi_data_i(wr_data[CNT_W-33:0]),
      .cnt_lo_o (lo_a[i]),
      .snap_o   (hi_a[i]),
      .ovf_o    (ovf[i])
    );
  end

  always_comb begin
    rdat = '0;
    if (dec.stat) begin
      rdat[CH_NUM-1:0] = ovf;
    end else begin
      for (int i = 0; i < CH_NUM; i++) begin
        if (dec.ch == 3'(i)) begin
          if (dec.lo) begin
            rdat = lo_a[i];
          end else if (dec.hi) begin
            rdat[CNT_W-33:0] = hi_a[i];
          end
        end
      end
    end
  end

  always_comb begin
    rd_valid_d = rd_en;
    rd_data_d  = rd_data_q;
    if (rd_en) begin
      rd_data_d = rdat;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_tdr_bank.sv
// Randomized + directed bench for tdr_bank against a
// behavioural register-level model (default parameters).
module tb_tdr_bank;

  localparam logic [11:0] BASE = 12'h4;
  localparam logic [11:0] STAT = 12'h40;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        wr_en   = 1'b0;
  logic        rd_en   = 1'b0;
  logic [11:0] addr    = '0;
  logic [31:0] wr_data = '0;
  logic [1:0]  cnt_en  = '0;
  logic        halt    = 1'b0;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic [1:0]  ovf;

  int checks = 0;
  int errors = 0;

  logic [63:0] m_cnt  [2];
  logic [31:0] m_shad [2];
  logic [31:0] m_snap [2];
  logic [1:0]  m_ovf;
  logic [31:0] m_rd;
  logic        m_vld;

  tdr_bank dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .wr_en   (wr_en),
    .rd_en   (rd_en),
    .addr    (addr),
    .wr_data (wr_data),
    .cnt_en  (cnt_en),
    .halt    (halt),
    .rd_data (rd_data),
    .rd_valid(rd_valid),
    .ovf     (ovf)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Reference: apply one access/count cycle to the register model.
  task automatic model(input logic we, input logic re,
                       input logic [11:0] a, input logic [31:0] d,
                       input logic [1:0] en, input logic h,
                       input logic rst);
    logic [63:0] c0 [2];
    logic [1:0]  wrap;
    if (rst) begin
      for (int n = 0; n < 2; n++) begin
        m_cnt[n] = 0; m_shad[n] = 0; m_snap[n] = 0;
      end
      m_ovf = 0; m_rd = 0; m_vld = 0;
      return;
    end
    c0[0] = m_cnt[0];
    c0[1] = m_cnt[1];
    m_vld = re;
    if (re) begin
      m_rd = 0;
      if (a == STAT) m_rd = {30'd0, m_ovf};
      for (int n = 0; n < 2; n++) begin
        if (a == BASE + 12'(8*n)) begin
          m_rd = c0[n][31:0];
          m_snap[n] = c0[n][63:32];
        end
        if (a == BASE + 12'(8*n + 4)) m_rd = m_snap[n];
      end
    end
    wrap = 0;
    for (int n = 0; n < 2; n++) begin
      if (we && a == BASE + 12'(8*n + 4))
        m_cnt[n] = {d, m_shad[n]};
      else if (en[n] && !h) begin
        if (c0[n] == 64'hFFFF_FFFF_FFFF_FFFF) wrap[n] = 1;
        m_cnt[n] = c0[n] + 1;
      end
    end
    if (we && a == STAT) m_ovf = m_ovf & ~d[1:0];
    m_ovf = m_ovf | wrap;
    for (int n = 0; n < 2; n++)
      if (we && a == BASE + 12'(8*n)) m_shad[n] = d;
  endtask

  task automatic cyc(input logic we, input logic re,
                     input logic [11:0] a, input logic [31:0] d,
                     input logic [1:0] en, input logic h,
                     input logic rst);
    wr_en = we; rd_en = re; addr = a; wr_data = d;
    cnt_en = en; halt = h; sys_rst = rst;
    model(we, re, a, d, en, h, rst);
    @(posedge sys_clk);
    #1;
    chk("rd_valid", 64'(rd_valid), 64'(m_vld));
    chk("rd_data", 64'(rd_data), 64'(m_rd));
    chk("ovf", 64'(ovf), 64'(m_ovf));
  endtask

  task automatic idle(input logic [1:0] en);
    cyc(0, 0, 12'h0, 0, en, 0, 0);
  endtask

  logic [11:0] pick [7];

  initial begin
    pick = '{12'h4, 12'h8, 12'hC, 12'h10, 12'h40, 12'h3C, 12'h6};

    // Reset state
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("rst_rd_data", 64'(rd_data), 0);
    chk("rst_ovf", 64'(ovf), 0);

    // Count 10 on channel 0, then read both channels
    repeat (10) idle(2'b01);
    cyc(0, 1, 12'h4, 0, 0, 0, 0);
    chk("ch0_count10", 64'(rd_data), 10);
    chk("ch0_valid", 64'(rd_valid), 1);
    cyc(0, 1, 12'hC, 0, 0, 0, 0);
    chk("ch1_zero", 64'(rd_data), 0);
    idle(0);
    chk("valid_drop", 64'(rd_valid), 0);
    chk("rd_hold", 64'(rd_data), 0);

    // Wrap: load all-ones minus one, count twice
    cyc(1, 0, 12'h4, 32'hFFFF_FFFE, 0, 0, 0);
    cyc(1, 0, 12'h8, 32'hFFFF_FFFF, 0, 0, 0);
    idle(2'b01);
    chk("no_ovf_yet", 64'(ovf), 0);
    idle(2'b01);
    chk("wrap_ovf", 64'(ovf), 1);
    cyc(0, 1, STAT, 0, 0, 0, 0);
    chk("stat_read", 64'(rd_data), 1);

    // Coherent snapshot across a carry
    cyc(1, 0, 12'h4, 32'hFFFF_FFFF, 2'b01, 0, 0);
    cyc(1, 0, 12'h8, 32'h1, 2'b01, 0, 0);
    cyc(0, 1, 12'h4, 0, 2'b01, 0, 0);
    chk("snap_lo", 64'(rd_data), 64'hFFFF_FFFF);
    repeat (2) idle(2'b01);
    cyc(0, 1, 12'h8, 0, 2'b01, 0, 0);
    chk("snap_hi", 64'(rd_data), 1);

    // W1C racing a wrap keeps the flag, then clears it
    cyc(1, 0, STAT, 32'h3, 0, 0, 0);
    chk("w1c_clear", 64'(ovf), 0);
    cyc(1, 0, 12'h4, 32'hFFFF_FFFF, 0, 0, 0);
    cyc(1, 0, 12'h8, 32'hFFFF_FFFF, 0, 0, 0);
    cyc(1, 0, STAT, 32'h1, 2'b01, 0, 0);
    chk("w1c_vs_wrap", 64'(ovf), 1);
    cyc(1, 0, STAT, 32'h1, 0, 0, 0);
    chk("w1c_after", 64'(ovf), 0);

    // Reset with concurrent MSB write and read
    repeat (3) idle(2'b11);
    cyc(1, 1, 12'h8, 32'h1234, 2'b11, 0, 1);
    chk("rst_valid", 64'(rd_valid), 0);
    chk("rst_data", 64'(rd_data), 0);
    cyc(0, 1, 12'h4, 0, 0, 0, 0);
    chk("rst_cnt", 64'(rd_data), 0);

    // Unmapped access
    cyc(0, 1, 12'h3C, 0, 0, 0, 0);
    chk("unmap_data", 64'(rd_data), 0);
    chk("unmap_valid", 64'(rd_valid), 1);
    cyc(1, 0, 12'h3C, 32'hDEAD_BEEF, 0, 0, 0);
    cyc(0, 1, 12'h4, 0, 0, 0, 0);
    chk("unmap_nowr", 64'(rd_data), 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [11:0] a;
      logic [31:0] d;
      a = ($urandom_range(0, 9) == 0) ? 12'($urandom)
                                      : pick[$urandom_range(0, 6)];
      d = $urandom_range(0, 1) ? $urandom
                               : 32'hFFFF_FFFF - $urandom_range(0, 3);
      cyc($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
          a, d, 2'($urandom), $urandom_range(0, 7) == 0,
          $urandom_range(0, 99) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
